// File: rtl/div_iter32.sv
// Restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept and complete in a single cycle.
module div_iter32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             sel_rem;
   logic             q_neg;
   logic             r_neg;

   logic             accept;
   logic             is_signed;
   logic             div_zero;
   logic             sgn_ovf;
   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // The stored remainder is always below the divisor, so WIDTH bits hold it;
   // the extra bit only exists in the shifted/trial values.
   always_comb begin
      is_signed = ~op[0];
      abs1      = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
      abs2      = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
      div_zero  = (src2 == '0);
      sgn_ovf   = is_signed && (src1 == MIN_NEG) && (src2 == '1);
      accept    = in_valid && (state == IDLE) && !flush;
      shifted   = {rem, quo[WIDTH-1]};
      diff      = shifted - {1'b0, dvs};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (div_zero || sgn_ovf) ? DONE : CALC;
         CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIXUP;
         FIXUP:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         cnt     <= '0;
         sel_rem <= 1'b0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sel_rem <= op[1];
                  q_neg   <= is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                  r_neg   <= is_signed & src1[WIDTH-1];
                  rem     <= '0;
                  quo     <= abs1;
                  dvs     <= abs2;
                  cnt     <= '0;
                  if (div_zero)     result <= op[1] ? src1 : '1;
                  else if (sgn_ovf) result <= op[1] ? '0 : src1;
               end
            end
            CALC: begin
               if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
            end
            FIXUP: begin
               if (!flush) begin
                  if (sel_rem) result <= r_neg ? -rem : rem;
                  else         result <= q_neg ? -quo : quo;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule
